// File: rtl/snn_rate_decoder.sv
// Rate decoder for the snn_2layer spike vector: counts spikes per neuron over a
// window of enabled cycles, then holds counts, argmax, tie and silence for a valid/ready consumer.
module snn_rate_decoder #(
  parameter int N2     = 2,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = (N2 > 1) ? $clog2(N2) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [N2-1:0]         spike_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [N2*CNT_W-1:0]   count_out,
  output logic [IDX_W-1:0]      winner,
  output logic                  tie,
  output logic                  silent,
  output logic                  overrun
);

  localparam int               WIN_W   = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST    = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] acc [N2];
  logic [CNT_W-1:0] nxt [N2];
  logic [WIN_W-1:0] win_idx;
  logic [CNT_W-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic             multi_max;
  logic             all_zero;
  logic             window_end;

  // The snapshot is taken from the post-increment counts so the final cycle's spikes count.
  always_comb begin
    best       = '0;
    best_idx   = '0;
    multi_max  = 1'b0;
    all_zero   = 1'b1;
    window_end = enable && !clear && (win_idx == LAST);
    for (int i = 0; i < N2; i++) begin
      nxt[i] = (spike_in[i] && (acc[i] != CNT_MAX)) ? acc[i] + 1'b1 : acc[i];
    end
    for (int i = 0; i < N2; i++) begin
      if (nxt[i] > best) begin
        best     = nxt[i];
        best_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N2; i++) begin
      if ((nxt[i] == best) && (IDX_W'(i) != best_idx)) multi_max = 1'b1;
      if (nxt[i] != '0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N2; i++) acc[i] <= '0;
      win_idx   <= '0;
      out_valid <= 1'b0;
      count_out <= '0;
      winner    <= '0;
      tie       <= 1'b0;
      silent    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clear || window_end) begin
        for (int i = 0; i < N2; i++) acc[i] <= '0;
        win_idx <= '0;
      end else if (enable) begin
        for (int i = 0; i < N2; i++) acc[i] <= nxt[i];
        win_idx <= win_idx + 1'b1;
      end

      // A new snapshot wins over an accept at the same edge; overwriting an unread result is sticky.
      if (window_end) begin
        for (int i = 0; i < N2; i++) count_out[i*CNT_W +: CNT_W] <= nxt[i];
        winner    <= best_idx;
        tie       <= multi_max;
        silent    <= all_zero;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snn_rate_decoder.sv
// Testbench for snn_rate_decoder: directed scenarios plus a randomized run against a
// window-queue reference model, on a default instance and a CNT_W=3 instance.
module tb_snn_rate_decoder;

  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] spike_in = 2'b00;

  logic        valid_a, tie_a, silent_a, overrun_a;
  logic [15:0] count_a;
  logic [0:0]  winner_a;
  logic        valid_b, tie_b, silent_b, overrun_b;
  logic [5:0]  count_b;
  logic [0:0]  winner_b;

  int checks = 0;
  int errors = 0;

  logic [1:0] win_q[$];
  bit m_valid, m_overrun;
  int m_cnt_a[2];
  int m_cnt_b[2];
  int m_win_a, m_win_b;
  bit m_tie_a, m_tie_b, m_sil_a, m_sil_b;

  snn_rate_decoder #(.N2(2), .WINDOW(WINDOW), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
    .out_ready(out_ready), .out_valid(valid_a), .count_out(count_a), .winner(winner_a),
    .tie(tie_a), .silent(silent_a), .overrun(overrun_a));

  snn_rate_decoder #(.N2(2), .WINDOW(WINDOW), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .spike_in(spike_in),
    .out_ready(out_ready), .out_valid(valid_b), .count_out(count_b), .winner(winner_b),
    .tie(tie_b), .silent(silent_b), .overrun(overrun_b));

  always #5 clk = ~clk;

  function automatic void rank(input int c0, input int c1, output int w, output bit t, output bit s);
    w = (c1 > c0) ? 1 : 0;
    t = (c0 == c1);
    s = (c0 == 0) && (c1 == 0);
  endfunction

  task automatic model_reset();
    win_q.delete();
    m_valid = 0; m_overrun = 0;
    m_cnt_a = '{0, 0}; m_cnt_b = '{0, 0};
    m_win_a = 0; m_win_b = 0;
    m_tie_a = 0; m_tie_b = 0; m_sil_a = 0; m_sil_b = 0;
  endtask

  // Reference: remember every enabled spike vector of the window, sum them when it fills.
  task automatic model_edge();
    bit snap;
    int s0, s1;
    snap = 0; s0 = 0; s1 = 0;
    if (clear) begin
      win_q.delete();
    end else if (enable) begin
      win_q.push_back(spike_in);
      if (win_q.size() == WINDOW) begin
        foreach (win_q[k]) begin
          s0 += int'(win_q[k][0]);
          s1 += int'(win_q[k][1]);
        end
        m_cnt_a[0] = (s0 > 255) ? 255 : s0;
        m_cnt_a[1] = (s1 > 255) ? 255 : s1;
        m_cnt_b[0] = (s0 > 7) ? 7 : s0;
        m_cnt_b[1] = (s1 > 7) ? 7 : s1;
        rank(m_cnt_a[0], m_cnt_a[1], m_win_a, m_tie_a, m_sil_a);
        rank(m_cnt_b[0], m_cnt_b[1], m_win_b, m_tie_b, m_sil_b);
        if (m_valid && !out_ready) m_overrun = 1;
        m_valid = 1;
        snap = 1;
        win_q.delete();
      end
    end
    if (!snap && m_valid && out_ready) m_valid = 0;
  endtask

  task automatic step(input logic en, input logic clr, input logic [1:0] sp, input logic rdy);
    enable = en; clear = clr; spike_in = sp; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      spike_in = 2'($urandom_range(3));
      enable = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
      checks++;
      if ({valid_a, count_a, winner_a, tie_a, silent_a, overrun_a} !== 21'd0) begin
        errors++; $display("[TB] FAIL reset_a: got %h expected 0", {valid_a, count_a, winner_a, tie_a, silent_a, overrun_a});
      end
      checks++;
      if ({valid_b, count_b, winner_b, tie_b, silent_b, overrun_b} !== 11'd0) begin
        errors++; $display("[TB] FAIL reset_b: got %h expected 0", {valid_b, count_b, winner_b, tie_b, silent_b, overrun_b});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_neuron();
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 2'b01, 1'b1);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %0d expected 0", valid_a); end
    step(1'b1, 1'b0, 2'b01, 1'b1);
    checks++;
    if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0d expected 1", valid_a); end
    checks++;
    if (count_a[7:0] !== 8'd16) begin errors++; $display("[TB] FAIL single_count0: got %0d expected 16", count_a[7:0]); end
    checks++;
    if (count_a[15:8] !== 8'd0) begin errors++; $display("[TB] FAIL single_count1: got %0d expected 0", count_a[15:8]); end
    checks++;
    if ({winner_a, tie_a, silent_a} !== 3'b000) begin errors++; $display("[TB] FAIL single_flags: got %b expected 000", {winner_a, tie_a, silent_a}); end
    checks++;
    if (count_b !== 6'o07) begin errors++; $display("[TB] FAIL sat_counts: got %o expected 07", count_b); end
    checks++;
    if (winner_b !== 1'b0) begin errors++; $display("[TB] FAIL sat_winner: got %0d expected 0", winner_b); end
    step(1'b0, 1'b0, 2'b00, 1'b1);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL single_accept: got %0d expected 0", valid_a); end
  endtask

  task automatic test_tie_silent();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, (k % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
    checks++;
    if (count_a !== {8'd8, 8'd8}) begin errors++; $display("[TB] FAIL tie_counts: got %h expected 0808", count_a); end
    checks++;
    if ({valid_a, winner_a, tie_a, silent_a} !== 4'b1010) begin errors++; $display("[TB] FAIL tie_flags: got %b expected 1010", {valid_a, winner_a, tie_a, silent_a}); end
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 2'b00, 1'b1);
    checks++;
    if ({valid_a, winner_a, tie_a, silent_a, overrun_a} !== 5'b10110) begin errors++; $display("[TB] FAIL silent_flags: got %b expected 10110", {valid_a, winner_a, tie_a, silent_a, overrun_a}); end
    checks++;
    if (count_a !== 16'd0) begin errors++; $display("[TB] FAIL silent_counts: got %h expected 0000", count_a); end
    step(1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 2'b10, 1'b0);
    checks++;
    if ({valid_a, winner_a, overrun_a} !== 3'b110) begin errors++; $display("[TB] FAIL ovr_first: got %b expected 110", {valid_a, winner_a, overrun_a}); end
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 2'b01, 1'b0);
    checks++;
    if (count_a !== {8'd0, 8'd16}) begin errors++; $display("[TB] FAIL ovr_counts: got %h expected 0010", count_a); end
    checks++;
    if ({valid_a, winner_a, overrun_a} !== 3'b101) begin errors++; $display("[TB] FAIL ovr_second: got %b expected 101", {valid_a, winner_a, overrun_a}); end
    step(1'b0, 1'b0, 2'b00, 1'b1);
    checks++;
    if ({valid_a, overrun_a} !== 2'b01) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 01", {valid_a, overrun_a}); end
  endtask

  task automatic test_pause_clear();
    bit saw_valid;
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 2'b11, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 2'b11, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 2'b11, 1'b0);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL pause_early: got %0d expected 0", valid_a); end
    step(1'b1, 1'b0, 2'b11, 1'b0);
    checks++;
    if (valid_a !== 1'b1 || count_a !== {8'd16, 8'd16}) begin errors++; $display("[TB] FAIL pause_result: got %0d/%h expected 1/1010", valid_a, count_a); end
    checks++;
    if ({winner_a, tie_a, silent_a} !== 3'b010) begin errors++; $display("[TB] FAIL pause_flags: got %b expected 010", {winner_a, tie_a, silent_a}); end
    checks++;
    if (count_b !== 6'o77 || tie_b !== 1'b1) begin errors++; $display("[TB] FAIL pause_sat: got %o/%0d expected 77/1", count_b, tie_b); end
    step(1'b0, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0);
    saw_valid = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b0, 2'b10, 1'b0);
      if (valid_a === 1'b1) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin errors++; $display("[TB] FAIL clear_no_snapshot: got 1 expected 0"); end
    step(1'b1, 1'b0, 2'b10, 1'b0);
    checks++;
    if (valid_a !== 1'b1 || count_a !== {8'd16, 8'd0} || winner_a !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_window: got %0d/%h/%0d expected 1/1000/1", valid_a, count_a, winner_a);
    end
  endtask

  task automatic test_reset_midwindow();
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 2'b01, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({valid_a, count_a, winner_a, tie_a, silent_a, overrun_a} !== 21'd0) begin
      errors++; $display("[TB] FAIL midreset_a: got %h expected 0", {valid_a, count_a, winner_a, tie_a, silent_a, overrun_a});
    end
    checks++;
    if ({valid_b, count_b, winner_b} !== 8'd0) begin errors++; $display("[TB] FAIL midreset_b: got %h expected 0", {valid_b, count_b, winner_b}); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 2'b01, 1'b1);
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_early: got %0d expected 0", valid_a); end
    step(1'b1, 1'b0, 2'b01, 1'b1);
    checks++;
    if (valid_a !== 1'b1 || count_a[7:0] !== 8'd16 || count_b[2:0] !== 3'd7) begin
      errors++; $display("[TB] FAIL midreset_window: got %0d/%0d/%0d expected 1/16/7", valid_a, count_a[7:0], count_b[2:0]);
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 800; k++) begin
      step(1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0), 2'($urandom_range(3)), 1'($urandom_range(3) == 0));
      checks++;
      if (valid_a !== 1'(m_valid) || valid_b !== 1'(m_valid)) begin
        errors++; $display("[TB] FAIL rand_valid@%0d: got %0d/%0d expected %0d", k, valid_a, valid_b, m_valid);
      end
      checks++;
      if (overrun_a !== 1'(m_overrun) || overrun_b !== 1'(m_overrun)) begin
        errors++; $display("[TB] FAIL rand_overrun@%0d: got %0d/%0d expected %0d", k, overrun_a, overrun_b, m_overrun);
      end
      checks++;
      if (int'(count_a[7:0]) != m_cnt_a[0] || int'(count_a[15:8]) != m_cnt_a[1]) begin
        errors++; $display("[TB] FAIL rand_count_a@%0d: got %0d,%0d expected %0d,%0d", k, count_a[7:0], count_a[15:8], m_cnt_a[0], m_cnt_a[1]);
      end
      checks++;
      if (int'(count_b[2:0]) != m_cnt_b[0] || int'(count_b[5:3]) != m_cnt_b[1]) begin
        errors++; $display("[TB] FAIL rand_count_b@%0d: got %0d,%0d expected %0d,%0d", k, count_b[2:0], count_b[5:3], m_cnt_b[0], m_cnt_b[1]);
      end
      checks++;
      if (int'(winner_a) != m_win_a || tie_a !== 1'(m_tie_a) || silent_a !== 1'(m_sil_a)) begin
        errors++; $display("[TB] FAIL rand_flags_a@%0d: got %0d%0d%0d expected %0d%0d%0d", k, winner_a, tie_a, silent_a, m_win_a, m_tie_a, m_sil_a);
      end
      checks++;
      if (int'(winner_b) != m_win_b || tie_b !== 1'(m_tie_b) || silent_b !== 1'(m_sil_b)) begin
        errors++; $display("[TB] FAIL rand_flags_b@%0d: got %0d%0d%0d expected %0d%0d%0d", k, winner_b, tie_b, silent_b, m_win_b, m_tie_b, m_sil_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_neuron();
    test_tie_silent();
    test_overrun();
    test_reset();
    test_pause_clear();
    test_reset_midwindow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
